// File: rtl/crballoon_pkg.sv
// Shared types and default stream indices for the CRAZYBALLOON ROM loader.
package crballoon_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    HOLD
  } loader_state_t;

  localparam logic [7:0]  ROM_INDEX_DEF   = 8'd0;
  localparam logic [7:0]  DIP_INDEX_DEF   = 8'd254;
  localparam int unsigned ROM_SIZE_DEF    = 16384;
  localparam int unsigned DIP_BYTES_DEF   = 8;
  localparam int unsigned HOLD_CYCLES_DEF = 1024;

endpackage

// File: rtl/crballoon_reset_stretch.sv
// Down-counter that stretches core reset; reload wins over decrement, done when it reaches zero.
module crballoon_reset_stretch #(
  parameter int unsigned HOLD_CYCLES = 1024
) (
  input  logic CLK,
  input  logic RESET,
  input  logic reload,
  input  logic dec,
  output logic done
);

  localparam int unsigned CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] RELOAD_VAL = CW'(HOLD_CYCLES - 1);

  logic [CW-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (reload) begin
      cnt_d = RELOAD_VAL;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt_q <= RELOAD_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/crballoon_rom_loader.sv
// hps_io download demux for CRAZYBALLOON: ROM write port, DIP bank and core reset sequencing.
module crballoon_rom_loader
  import crballoon_pkg::*;
#(
  parameter int unsigned ROM_SIZE    = ROM_SIZE_DEF,
  parameter logic [7:0]  ROM_INDEX   = ROM_INDEX_DEF,
  parameter logic [7:0]  DIP_INDEX   = DIP_INDEX_DEF,
  parameter int unsigned DIP_BYTES   = DIP_BYTES_DEF,
  parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEF
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic        user_reset,
  output logic [15:0] dn_addr,
  output logic [7:0]  dn_data,
  output logic        dn_wr,
  output logic        dn_ld,
  output logic [63:0] dipsw,
  output logic        core_reset,
  output logic        rom_ok,
  output logic        rom_oversize
);

  localparam logic [24:0] ROM_LIMIT = 25'(ROM_SIZE);
  localparam logic [24:0] DIP_LIMIT = 25'(DIP_BYTES);
  localparam logic [16:0] ROM_FULL  = 17'(ROM_SIZE);

  loader_state_t state_d, state_q;
  logic [15:0] dn_addr_d, dn_addr_q;
  logic [7:0]  dn_data_d, dn_data_q;
  logic        dn_wr_d, dn_wr_q;
  logic        dn_ld_d, dn_ld_q;
  logic [63:0] dipsw_d, dipsw_q;
  logic        core_reset_d, core_reset_q;
  logic        rom_ok_d, rom_ok_q;
  logic        rom_ovs_d, rom_ovs_q;
  logic [16:0] rom_cnt_d, rom_cnt_q, rom_cnt_base;
  logic        dl_any_q;

  logic wr_ok, rom_hit, rom_acc, rom_big, dip_acc;
  logic dl_rise, dl_fall, dl_rom_rise, dl_rom_fall;
  logic hold_reload, hold_dec, hold_done;

  crballoon_reset_stretch #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_stretch (
    .CLK   (CLK),
    .RESET (RESET),
    .reload(hold_reload),
    .dec   (hold_dec),
    .done  (hold_done)
  );

  // Stream demux and ROM completeness tracking.
  always_comb begin
    dn_ld_d     = ioctl_download && (ioctl_index == ROM_INDEX);
    dl_rom_rise = dn_ld_d && !dn_ld_q;
    dl_rom_fall = !dn_ld_d && dn_ld_q;
    dl_rise     = ioctl_download && !dl_any_q;
    dl_fall     = !ioctl_download && dl_any_q;

    wr_ok   = ioctl_wr && ioctl_download;
    rom_hit = wr_ok && (ioctl_index == ROM_INDEX);
    rom_acc = rom_hit && (ioctl_addr < ROM_LIMIT);
    rom_big = rom_hit && !(ioctl_addr < ROM_LIMIT);
    dip_acc = wr_ok && (ioctl_index == DIP_INDEX) && (ioctl_addr < DIP_LIMIT);

    dn_wr_d   = rom_acc;
    dn_addr_d = rom_acc ? ioctl_addr[15:0] : dn_addr_q;
    dn_data_d = rom_acc ? ioctl_dout : dn_data_q;

    dipsw_d = dipsw_q;
    if (dip_acc) begin
      dipsw_d[{ioctl_addr[2:0], 3'b000} +: 8] = ioctl_dout;
    end

    rom_cnt_base = dl_rom_rise ? '0 : rom_cnt_q;
    rom_cnt_d    = rom_cnt_base;
    if (rom_acc && (rom_cnt_base != ROM_FULL)) begin
      rom_cnt_d = rom_cnt_base + 1'b1;
    end

    rom_ovs_d = (dl_rom_rise ? 1'b0 : rom_ovs_q) || rom_big;

    rom_ok_d = dl_rom_rise ? 1'b0 : rom_ok_q;
    if (dl_rom_fall) begin
      rom_ok_d = (rom_cnt_q == ROM_FULL);
    end
  end

  // Core reset sequencing; a download start pre-empts any pending stretch.
  always_comb begin
    state_d     = state_q;
    hold_reload = 1'b0;
    hold_dec    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (dl_rise) begin
          state_d = LOAD;
        end else if (user_reset) begin
          state_d     = HOLD;
          hold_reload = 1'b1;
        end
      end
      LOAD: begin
        if (dl_fall) begin
          state_d     = HOLD;
          hold_reload = 1'b1;
        end
      end
      HOLD: begin
        if (dl_rise) begin
          state_d = LOAD;
        end else if (user_reset) begin
          hold_reload = 1'b1;
        end else if (hold_done) begin
          state_d = IDLE;
        end else begin
          hold_dec = 1'b1;
        end
      end
      default: state_d = HOLD;
    endcase
    core_reset_d = (state_d == IDLE) ? !rom_ok_d : 1'b1;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= HOLD;
      dn_addr_q    <= '0;
      dn_data_q    <= '0;
      dn_wr_q      <= 1'b0;
      dn_ld_q      <= 1'b0;
      dipsw_q      <= '0;
      core_reset_q <= 1'b1;
      rom_ok_q     <= 1'b0;
      rom_ovs_q    <= 1'b0;
      rom_cnt_q    <= '0;
      dl_any_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      dn_addr_q    <= dn_addr_d;
      dn_data_q    <= dn_data_d;
      dn_wr_q      <= dn_wr_d;
      dn_ld_q      <= dn_ld_d;
      dipsw_q      <= dipsw_d;
      core_reset_q <= core_reset_d;
      rom_ok_q     <= rom_ok_d;
      rom_ovs_q    <= rom_ovs_d;
      rom_cnt_q    <= rom_cnt_d;
      dl_any_q     <= ioctl_download;
    end
  end

  assign dn_addr      = dn_addr_q;
  assign dn_data      = dn_data_q;
  assign dn_wr        = dn_wr_q;
  assign dn_ld        = dn_ld_q;
  assign dipsw        = dipsw_q;
  assign core_reset   = core_reset_q;
  assign rom_ok       = rom_ok_q;
  assign rom_oversize = rom_ovs_q;

endmodule

// File: tb/tb_crballoon_rom_loader.sv
// Scoreboard bench for crballoon_rom_loader: ROM stream, DIP bank, reset sequencing.
module tb_crballoon_rom_loader;

  localparam int unsigned ROM_SIZE  = 16384;
  localparam int unsigned HOLD      = 1024;
  localparam logic [7:0]  ROM_IDX   = 8'd0;
  localparam logic [7:0]  DIP_IDX   = 8'd254;
  localparam logic [24:0] ROM_LIM   = 25'(ROM_SIZE);
  localparam logic [24:0] DIP_LIM   = 25'd8;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = '0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        user_reset = 1'b0;
  logic [15:0] dn_addr;
  logic [7:0]  dn_data;
  logic        dn_wr, dn_ld, core_reset, rom_ok, rom_oversize;
  logic [63:0] dipsw;

  crballoon_rom_loader #(
    .ROM_SIZE   (ROM_SIZE),
    .ROM_INDEX  (ROM_IDX),
    .DIP_INDEX  (DIP_IDX),
    .DIP_BYTES  (8),
    .HOLD_CYCLES(HOLD)
  ) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .ioctl_download(ioctl_download),
    .ioctl_index   (ioctl_index),
    .ioctl_wr      (ioctl_wr),
    .ioctl_addr    (ioctl_addr),
    .ioctl_dout    (ioctl_dout),
    .user_reset    (user_reset),
    .dn_addr       (dn_addr),
    .dn_data       (dn_data),
    .dn_wr         (dn_wr),
    .dn_ld         (dn_ld),
    .dipsw         (dipsw),
    .core_reset    (core_reset),
    .rom_ok        (rom_ok),
    .rom_oversize  (rom_oversize)
  );

  always #5 CLK = ~CLK;

  int unsigned cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  logic [23:0] exp_q[$];
  logic [7:0]  m_dip[8];
  int unsigned m_cnt;
  logic        m_ok, m_ovs;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic monitor();
    logic [23:0] e;
    forever begin
      @(negedge CLK);
      if (dn_wr === 1'b1) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL dn_wr_unexpected: got addr %h data %h, expected no write", dn_addr, dn_data);
        end else begin
          e = exp_q.pop_front();
          if ({dn_addr, dn_data} !== e) begin
            fails++;
            $display("FAIL dn_wr_stream: got %h, expected %h", {dn_addr, dn_data}, e);
          end
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic ioctl_write(input logic [24:0] a, input logic [7:0] d);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    if (ioctl_download) begin
      if (ioctl_index == ROM_IDX) begin
        if (a < ROM_LIM) begin
          exp_q.push_back({a[15:0], d});
          m_cnt++;
        end else begin
          m_ovs = 1'b1;
        end
      end else if (ioctl_index == DIP_IDX && a < DIP_LIM) begin
        m_dip[a[2:0]] = d;
      end
    end
    tick();
    ioctl_wr = 1'b0;
    if ($urandom_range(1, 0) == 1) tick();
  endtask

  task automatic dl_start(input logic [7:0] idx);
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    if (idx == ROM_IDX) begin
      m_cnt = 0;
      m_ovs = 1'b0;
      m_ok  = 1'b0;
    end
    tick();
    check("dn_ld_window", {63'd0, dn_ld}, {63'd0, idx == ROM_IDX});
    check("core_reset_in_load", {63'd0, core_reset}, 64'd1);
  endtask

  task automatic dl_end(output int unsigned t0);
    ioctl_download = 1'b0;
    if (ioctl_index == ROM_IDX) m_ok = (m_cnt >= ROM_SIZE);
    tick();
    t0 = cyc;
    check("rom_ok_after_dl", {63'd0, rom_ok}, {63'd0, m_ok});
    check("rom_oversize_after_dl", {63'd0, rom_oversize}, {63'd0, m_ovs});
  endtask

  task automatic expect_release(input string name, input int unsigned t0, input bit exp_rel);
    bit dropped = 1'b0;
    int unsigned elapsed = 0;
    for (int unsigned k = 0; k < HOLD + 64; k++) begin
      tick();
      if (core_reset === 1'b0) begin
        dropped = 1'b1;
        elapsed = cyc - t0;
        break;
      end
    end
    if (exp_rel) check(name, dropped ? 64'(elapsed) : 64'hFFFF_FFFF, 64'(HOLD));
    else         check(name, {63'd0, dropped}, 64'd0);
  endtask

  task automatic check_dip(input string name);
    logic [63:0] e;
    for (int i = 0; i < 8; i++) e[8*i +: 8] = m_dip[i];
    check(name, dipsw, e);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_dn_addr"}, 64'(dn_addr), 64'd0);
    check({tag, "_dn_data"}, 64'(dn_data), 64'd0);
    check({tag, "_dn_wr"}, {63'd0, dn_wr}, 64'd0);
    check({tag, "_dn_ld"}, {63'd0, dn_ld}, 64'd0);
    check({tag, "_dipsw"}, dipsw, 64'd0);
    check({tag, "_core_reset"}, {63'd0, core_reset}, 64'd1);
    check({tag, "_rom_ok"}, {63'd0, rom_ok}, 64'd0);
    check({tag, "_rom_oversize"}, {63'd0, rom_oversize}, 64'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned t0;
    for (int i = 0; i < 8; i++) m_dip[i] = 8'h00;
    m_cnt = 0; m_ok = 1'b0; m_ovs = 1'b0;
    fork
      monitor();
    join_none

    // Reset values, then idle with no ROM: core stays in reset.
    #1 RESET = 1'b1;
    #1 check_reset_outputs("reset");
    repeat (3) tick();
    RESET = 1'b0;
    expect_release("no_rom_stays_reset", cyc, 1'b0);
    check("no_rom_dn_wr", {63'd0, dn_wr}, 64'd0);

    // DIP bank: fixed pattern, out-of-range bytes, random rewrites.
    dl_start(DIP_IDX);
    for (int unsigned a = 0; a < 10; a++) ioctl_write(25'(a), 8'(8'hA0 + a));
    check("dip_pattern", dipsw, 64'hA7A6A5A4A3A2A1A0);
    for (int i = 0; i < 12; i++) ioctl_write(25'($urandom_range(15, 0)), 8'($urandom));
    check_dip("dip_random");
    dl_end(t0);
    // Writes without a download window must be ignored.
    for (int i = 0; i < 6; i++) begin
      ioctl_index = (i % 2 == 0) ? ROM_IDX : DIP_IDX;
      ioctl_write(25'($urandom_range(7, 0)), 8'($urandom));
    end
    check_dip("dip_no_window");
    check("sb_drain_dip", 64'(exp_q.size()), 64'd0);

    // Full ROM image plus saturating duplicates.
    dl_start(ROM_IDX);
    for (int unsigned a = 0; a < ROM_SIZE; a++) ioctl_write(25'(a), 8'(a));
    for (int i = 0; i < 20; i++) ioctl_write(25'($urandom_range(ROM_SIZE - 1, 0)), 8'($urandom));
    dl_end(t0);
    expect_release("rom_full_release", t0, 1'b1);
    check("sb_drain_full", 64'(exp_q.size()), 64'd0);

    // User reset from IDLE, then a second pulse in the middle of HOLD.
    user_reset = 1'b1;
    repeat (5) tick();
    check("user_reset_asserts", {63'd0, core_reset}, 64'd1);
    user_reset = 1'b0;
    expect_release("user_reset_idle", cyc, 1'b1);
    user_reset = 1'b1;
    repeat (5) tick();
    user_reset = 1'b0;
    repeat (300) tick();
    check("mid_hold_reset", {63'd0, core_reset}, 64'd1);
    user_reset = 1'b1;
    repeat (5) tick();
    user_reset = 1'b0;
    expect_release("user_reset_mid_hold", cyc, 1'b1);

    // Oversize addresses dropped and flagged.
    dl_start(ROM_IDX);
    ioctl_write(25'd16384, 8'h55);
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(1, 0) == 1) ioctl_write(25'($urandom_range(33554431, ROM_SIZE)), 8'($urandom));
      else                            ioctl_write(25'($urandom_range(ROM_SIZE - 1, 0)), 8'($urandom));
    end
    dl_end(t0);
    expect_release("oversize_stays_reset", t0, 1'b0);

    // Partial image.
    dl_start(ROM_IDX);
    for (int unsigned a = 0; a < 8000; a++) ioctl_write(25'(a), 8'($urandom));
    dl_end(t0);
    expect_release("partial_stays_reset", t0, 1'b0);
    check_dip("dip_persist");
    check("sb_drain_partial", 64'(exp_q.size()), 64'd0);

    // Asynchronous RESET in the middle of a ROM load.
    dl_start(ROM_IDX);
    for (int i = 0; i < 10; i++) ioctl_write(25'($urandom_range(ROM_SIZE - 1, 0)), 8'($urandom));
    tick();
    #2 RESET = 1'b1;
    #1 check_reset_outputs("async_reset");
    check("sb_drain_reset", 64'(exp_q.size()), 64'd0);
    for (int i = 0; i < 8; i++) m_dip[i] = 8'h00;
    ioctl_download = 1'b0;
    repeat (2) tick();
    RESET = 1'b0;
    expect_release("post_reset_stays", cyc, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
